// File: rtl/interrupt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_arbiter
//  Description : Latches UART interrupt events (overrun, parity, frame, RX
//                ready, config done), masks them with the ISR enable bits and
//                presents one pending interrupt at a time by fixed priority.
//                The registered ID and its load strobe feed ISR.INTID, and the
//                pending flag drives CTR.INTPEND.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_arbiter #(
    parameter int THR_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             overrun_error_i,
    input  logic             parity_error_i,
    input  logic             frame_error_i,
    input  logic             config_done_i,
    input  logic [THR_W:0]   rx_fifo_count_i,
    input  logic [THR_W-1:0] rx_fifo_threshold_i,
    input  logic             overrun_error_en_i,
    input  logic             parity_error_en_i,
    input  logic             frame_error_en_i,
    input  logic             rx_rdy_en_i,
    input  logic             enable_config_i,
    input  logic             int_ackn_i,
    output logic [2:0]       interrupt_id_o,
    output logic             interrupt_id_en_o,
    output logic             int_pend_o
);

    // Source index k carries interrupt ID k+1, so a lower index means a
    // higher priority: 0 overrun, 1 parity, 2 frame, 3 RX ready, 4 config.
    localparam int c_NUM_SRC = 5;
    localparam int c_CNT_W   = THR_W + 1;

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_PENDING = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_NUM_SRC-1:0] r_lat;
    logic [c_NUM_SRC-1:0] w_lat_nxt;
    logic [c_NUM_SRC-1:0] w_set;
    logic [c_NUM_SRC-1:0] w_en;
    logic [c_NUM_SRC-1:0] w_served;
    logic [2:0]           r_id;
    logic [2:0]           w_top_id;
    logic                 r_id_en;
    logic                 r_iack_q;
    logic                 w_iack_rise;
    logic                 w_pending;
    logic                 w_ack;
    logic [c_CNT_W-1:0]   w_thr_eff;
    logic                 w_rx_rdy;

    assign w_pending = (r_state == c_ST_PENDING);

    // A threshold of zero means "any non-empty FIFO", i.e. an effective
    // threshold of one entry.
    assign w_thr_eff = (rx_fifo_threshold_i == '0) ? c_CNT_W'(1)
                                                   : {1'b0, rx_fifo_threshold_i};
    assign w_rx_rdy  = (rx_fifo_count_i >= w_thr_eff);

    assign w_en = {enable_config_i, rx_rdy_en_i, frame_error_en_i,
                   parity_error_en_i, overrun_error_en_i};

    // RX ready is a level source: it re-sets its latch every cycle the FIFO
    // stays at or above threshold. Disabled sources are never latched.
    assign w_set = w_en & {config_done_i, w_rx_rdy, frame_error_i,
                           parity_error_i, overrun_error_i};

    // Only an IACK rising edge while an interrupt is pending acknowledges it;
    // edges seen in IDLE are dropped, and a held-high IACK counts once.
    assign w_iack_rise = int_ackn_i & ~r_iack_q;
    assign w_ack       = w_pending & w_iack_rise;

    // Per-source latch next state. A new set always wins over a clear, so a
    // fresh pulse of the served source during its ack re-raises it. A source
    // whose enable drops is cleared unless it is the one currently presented.
    genvar k;
    generate
        for (k = 0; k < c_NUM_SRC; k++) begin : g_src
            assign w_served[k]  = w_pending && (r_id == 3'(k + 1));
            assign w_lat_nxt[k] = w_set[k] |
                                  (r_lat[k] & ~((w_ack & w_served[k]) |
                                                (~w_en[k] & ~w_served[k])));
        end
    endgenerate

    // Event latches: hold each source until it is served or masked off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lat <= '0;
        end else begin
            r_lat <= w_lat_nxt;
        end
    end

    // IACK edge detector history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_iack_q <= 1'b0;
        end else begin
            r_iack_q <= int_ackn_i;
        end
    end

    // Fixed-priority encoder: lowest set index wins.
    always_comb begin
        w_top_id = 3'b000;
        for (int i = c_NUM_SRC - 1; i >= 0; i--) begin
            if (r_lat[i]) begin
                w_top_id = 3'(i + 1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: IDLE picks up any latched event; PENDING is left
    // only on acknowledge, so a higher-priority arrival never preempts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (|r_lat) begin
                    w_state_nxt = c_ST_PENDING;
                end
            end
            c_ST_PENDING: begin
                if (w_iack_rise) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Captured ID: sampled when leaving IDLE and frozen while pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_id <= 3'b000;
        end else if (!w_pending && (|r_lat)) begin
            r_id <= w_top_id;
        end
    end

    // Load strobe for ISR.INTID: one cycle after every state change, so both
    // the new ID and the return to 000 are written into the register block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_id_en <= 1'b0;
        end else begin
            r_id_en <= (w_state_nxt != r_state);
        end
    end

    // FSM outputs: the ID reads as 000 whenever nothing is pending.
    always_comb begin
        int_pend_o        = w_pending;
        interrupt_id_o    = w_pending ? r_id : 3'b000;
        interrupt_id_en_o = r_id_en;
    end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_arbiter
//  Description : Directed, table-driven bench for interrupt_arbiter. Each row
//                gives the inputs driven for one clock cycle together with the
//                outputs expected during that same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_arbiter;

    localparam int THR_W = 6;

    typedef struct {
        logic       rst;
        logic [3:0] p;     // pulses {cfg, frame, parity, overrun}
        logic [4:0] en;    // enables {cfg, rx_rdy, frame, parity, overrun}
        logic [6:0] cnt;
        logic [5:0] thr;
        logic       ack;
        logic       pend;
        logic [2:0] id;
        logic       iden;
    } vec_t;

    logic             r_clk = 1'b0;
    logic             r_rst;
    logic             r_ovr, r_par, r_frm, r_cfg;
    logic [THR_W:0]   r_cnt;
    logic [THR_W-1:0] r_thr;
    logic             r_ovr_en, r_par_en, r_frm_en, r_rx_en, r_cfg_en;
    logic             r_ack;
    logic [2:0]       w_id;
    logic             w_id_en;
    logic             w_pend;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[$];

    interrupt_arbiter #(.THR_W(THR_W)) dut (
        .clk_i               (r_clk),
        .rst_i               (r_rst),
        .overrun_error_i     (r_ovr),
        .parity_error_i      (r_par),
        .frame_error_i       (r_frm),
        .config_done_i       (r_cfg),
        .rx_fifo_count_i     (r_cnt),
        .rx_fifo_threshold_i (r_thr),
        .overrun_error_en_i  (r_ovr_en),
        .parity_error_en_i   (r_par_en),
        .frame_error_en_i    (r_frm_en),
        .rx_rdy_en_i         (r_rx_en),
        .enable_config_i     (r_cfg_en),
        .int_ackn_i          (r_ack),
        .interrupt_id_o      (w_id),
        .interrupt_id_en_o   (w_id_en),
        .int_pend_o          (w_pend)
    );

    always #5 r_clk = ~r_clk;

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rst, input logic [3:0] p,
                                input logic [4:0] en, input logic [6:0] cnt,
                                input logic [5:0] thr, input logic ack,
                                input logic pend, input logic [2:0] id,
                                input logic iden);
        vec_t t;
        t.rst = rst; t.p = p; t.en = en; t.cnt = cnt; t.thr = thr; t.ack = ack;
        t.pend = pend; t.id = id; t.iden = iden;
        return t;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0b expected %0b", name, idx, got, exp);
        end
    endtask

    // Drive one row just after a rising edge, compare outputs at the falling
    // edge of the same cycle, then advance to the next rising edge.
    task automatic step(input vec_t t, input int idx);
        r_rst = t.rst;
        {r_cfg, r_frm, r_par, r_ovr} = t.p;
        {r_cfg_en, r_rx_en, r_frm_en, r_par_en, r_ovr_en} = t.en;
        r_cnt = t.cnt;
        r_thr = t.thr;
        r_ack = t.ack;
        @(negedge r_clk);
        check("int_pend", idx, {2'b00, w_pend}, {2'b00, t.pend});
        check("int_id", idx, w_id, t.id);
        check("int_id_en", idx, {2'b00, w_id_en}, {2'b00, t.iden});
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        // ---------------- vector table ----------------
        //                rst p        en        cnt  thr ack  pend id      en
        // reset state and single parity event with ack
        vecs.push_back(mk(1, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0010, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd2, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd2, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   1, 3'd2, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        // overrun + frame together: 001 first, idle cycle, then 011
        vecs.push_back(mk(0, 4'b0101, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd1, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   1, 3'd1, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd3, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd3, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   1, 3'd3, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        // disabled frame pulse, enabled 5 cycles later: never raised
        vecs.push_back(mk(0, 4'b0100, 5'b11011, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11011, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11011, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11011, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11011, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        // RX threshold 4: count 3 none, count 4 raises, re-raise at ack+2
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 3, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 3, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 4, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 4, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 4, 4, 0,   1, 3'd4, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 4, 4, 1,   1, 3'd4, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 4, 4, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd4, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   1, 3'd4, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        // pending RX ready is not preempted by overrun
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 5, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0001, 5'b11111, 0, 4, 0,   1, 3'd4, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd4, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd4, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   1, 3'd4, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd1, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd1, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   1, 3'd1, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        // threshold 0 means any non-empty FIFO
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 0, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 0, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 1, 0, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 0, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 0, 0,   1, 3'd4, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 0, 1,   1, 3'd4, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 0, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 0, 0,   0, 3'd0, 0));
        // served source pulses again during its ack: set wins, re-raised
        vecs.push_back(mk(0, 4'b0010, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd2, 1));
        vecs.push_back(mk(0, 4'b0010, 5'b11111, 0, 4, 1,   1, 3'd2, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd2, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   1, 3'd2, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 1));
        // latched config event discarded when its enable drops
        vecs.push_back(mk(0, 4'b1010, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd2, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b01111, 0, 4, 0,   1, 3'd2, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   1, 3'd2, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        // config done alone -> ID 101
        vecs.push_back(mk(0, 4'b1000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   1, 3'd5, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 1,   1, 3'd5, 0));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, 5'b11111, 0, 4, 0,   0, 3'd0, 0));

        // ---------------- initial reset ----------------
        r_rst = 1'b1;
        {r_cfg, r_frm, r_par, r_ovr} = 4'b0000;
        {r_cfg_en, r_rx_en, r_frm_en, r_par_en, r_ovr_en} = 5'b11111;
        r_cnt = '0;
        r_thr = 6'd4;
        r_ack = 1'b0;
        @(posedge r_clk);
        #1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // ---------------- IACK held high for 10 cycles ----------------
        step(mk(0, 4'b0010, 5'b11111, 0, 4, 0, 0, 3'd0, 0), 1000);
        step(mk(0, 4'b0000, 5'b11111, 0, 4, 0, 0, 3'd0, 0), 1001);
        step(mk(0, 4'b0000, 5'b11111, 0, 4, 0, 1, 3'd2, 1), 1002);
        step(mk(0, 4'b0001, 5'b11111, 0, 4, 1, 1, 3'd2, 0), 1003);
        step(mk(0, 4'b0000, 5'b11111, 0, 4, 1, 0, 3'd0, 1), 1004);
        step(mk(0, 4'b0000, 5'b11111, 0, 4, 1, 1, 3'd1, 1), 1005);
        for (int j = 0; j < 7; j++) begin
            step(mk(0, 4'b0000, 5'b11111, 0, 4, 1, 1, 3'd1, 0), 1006 + j);
        end
        step(mk(0, 4'b0000, 5'b11111, 0, 4, 0, 1, 3'd1, 0), 1013);
        step(mk(0, 4'b0000, 5'b11111, 0, 4, 1, 1, 3'd1, 0), 1014);
        step(mk(0, 4'b0000, 5'b11111, 0, 4, 0, 0, 3'd0, 1), 1015);
        step(mk(0, 4'b0000, 5'b11111, 0, 4, 0, 0, 3'd0, 0), 1016);

        // ---------------- reset while pending ----------------
        step(mk(0, 4'b0100, 5'b11111, 0, 4, 0, 0, 3'd0, 0), 2000);
        step(mk(0, 4'b0000, 5'b11111, 0, 4, 0, 0, 3'd0, 0), 2001);
        step(mk(0, 4'b0001, 5'b11111, 0, 4, 0, 1, 3'd3, 1), 2002);
        step(mk(1, 4'b0000, 5'b11111, 0, 4, 0, 1, 3'd3, 0), 2003);
        for (int j = 0; j < 5; j++) begin
            step(mk(0, 4'b0000, 5'b11111, 0, 4, 0, 0, 3'd0, 0), 2004 + j);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
